// File: rtl/host_bus_if.sv
// host_bus_if
//
// Host-side front end for the VGA text controller's VRAM and bank register.
// The asynchronous host strobes are synchronized. A synced falling edge starts
// one access, which is decoded from the raw selects. VRAM accesses become a
// single-cycle request on the vram host port. Bank-register accesses are
// handled locally. Read data is captured into a register that the top level
// drives back onto the host bus.
//
// Parameters
//   SYNC_STAGES     synchronizer depth per strobe (2 or 3)
//
// Ports
//   clk             dot clock
//   rst             synchronous, active-high reset
//   hostBusAddr     host address, stable while a strobe is low
//   hostBusDataIn   host write data (input half of the bus tristate)
//   nHostRMEM       async active-low read strobe
//   nHostWMEM       async active-low write strobe
//   nHostVRAMEn     async active-low VRAM select
//   nHostBankRegEn  async active-low bank-register select
//   hostRdData      vram host-port read data, valid 1 clk after the request
//   hostAddr        vram host address {bank, latched hostBusAddr}
//   hostWrData      latched write data
//   hostSelect      one-clk vram access request
//   hostRd          access type, 1 = read, 0 = write
//   hostBusDataOut  read-data register
//   hostBusDataOe   tristate enable for hostBusDataOut
//   hostBusDir      transceiver direction, 0 = host read, 1 = host write
//   bank            current bank register value

module host_bus_if #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hostBusAddr,
  input  logic [7:0]  hostBusDataIn,
  input  logic        nHostRMEM,
  input  logic        nHostWMEM,
  input  logic        nHostVRAMEn,
  input  logic        nHostBankRegEn,
  input  logic [7:0]  hostRdData,
  output logic [12:0] hostAddr,
  output logic [7:0]  hostWrData,
  output logic        hostSelect,
  output logic        hostRd,
  output logic [7:0]  hostBusDataOut,
  output logic        hostBusDataOe,
  output logic        hostBusDir,
  output logic [1:0]  bank
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StWr    = 3'd1;
  localparam logic [2:0] StRd    = 3'd2;
  localparam logic [2:0] StRdCap = 3'd3;
  localparam logic [2:0] StHold  = 3'd4;

  // Strobe synchronizers and edge-detect history
  logic [SYNC_STAGES-1:0] rd_sync_q;
  logic [SYNC_STAGES-1:0] wr_sync_q;
  logic                   rd_hist_q;
  logic                   wr_hist_q;

  logic rd_synced;
  logic wr_synced;
  logic rd_start;
  logic wr_start;
  logic both_low;
  logic vram_sel;
  logic bank_sel;

  // Access state
  logic [2:0]  state_q, state_d;
  logic        is_vram_q, is_vram_d;
  logic [10:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [1:0]  bank_q, bank_d;
  logic [7:0]  rdata_q, rdata_d;

  assign rd_synced = rd_sync_q[SYNC_STAGES-1];
  assign wr_synced = wr_sync_q[SYNC_STAGES-1];

  // History and sync flops all reset low, so a strobe held low through reset
  // looks already-asserted and cannot start an access until it rises.
  assign rd_start = rd_hist_q & ~rd_synced;
  assign wr_start = wr_hist_q & ~wr_synced;

  // Both strobes low at the start means the host is misbehaving; do nothing.
  assign both_low = ~rd_synced & ~wr_synced;

  // Exactly one select low decodes to a target; anything else is no access.
  assign vram_sel = ~nHostVRAMEn & nHostBankRegEn;
  assign bank_sel = nHostVRAMEn & ~nHostBankRegEn;

  always_comb begin
    state_d   = state_q;
    is_vram_d = is_vram_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    bank_d    = bank_q;
    rdata_d   = rdata_q;

    case (state_q)
      StIdle: begin
        if (rd_start || wr_start) begin
          addr_d    = hostBusAddr;
          wdata_d   = hostBusDataIn;
          is_vram_d = vram_sel;
          if (both_low || !(vram_sel || bank_sel)) begin
            state_d = StHold;
          end else if (wr_start) begin
            state_d = StWr;
            // Bank write lands on the same edge as the address latch so the
            // new value is visible as soon as WR is entered.
            if (bank_sel) begin
              bank_d = hostBusDataIn[1:0];
            end
          end else begin
            state_d = StRd;
          end
        end
      end

      StWr: begin
        state_d = StHold;
      end

      StRd: begin
        state_d = StRdCap;
      end

      StRdCap: begin
        rdata_d = is_vram_q ? hostRdData : {6'b0, bank_q};
        state_d = StHold;
      end

      StHold: begin
        // One access per strobe pulse: wait for both strobes to be released.
        if (rd_synced && wr_synced) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_sync_q <= '0;
      wr_sync_q <= '0;
      rd_hist_q <= 1'b0;
      wr_hist_q <= 1'b0;
      state_q   <= StIdle;
      is_vram_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bank_q    <= '0;
      rdata_q   <= '0;
    end else begin
      rd_sync_q <= {rd_sync_q[SYNC_STAGES-2:0], nHostRMEM};
      wr_sync_q <= {wr_sync_q[SYNC_STAGES-2:0], nHostWMEM};
      rd_hist_q <= rd_synced;
      wr_hist_q <= wr_synced;
      state_q   <= state_d;
      is_vram_q <= is_vram_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      bank_q    <= bank_d;
      rdata_q   <= rdata_d;
    end
  end

  // WR and RD each last exactly one clk, so the request is a single pulse.
  assign hostSelect     = ((state_q == StWr) || (state_q == StRd)) && is_vram_q;
  assign hostRd         = (state_q != StWr);
  assign hostAddr       = {bank_q, addr_q};
  assign hostWrData     = wdata_q;
  assign hostBusDataOut = rdata_q;
  assign bank           = bank_q;

  // Bus turnaround follows the raw pins so the transceiver flips without
  // waiting on the synchronizers.
  assign hostBusDataOe  = ~nHostRMEM & (nHostVRAMEn ^ nHostBankRegEn);
  assign hostBusDir     = ~hostBusDataOe;

endmodule

// File: doc/host_bus_if.md
# host_bus_if

Host-side front end for the VGA text controller's VRAM and bank register. It synchronizes the asynchronous host memory strobes, decodes VRAM and bank-register accesses, and issues single-cycle read/write requests to the host port of `vram`. It returns read data to the host bus and drives the bus-direction control. It replaces the constant host-port tie-offs in the top level.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: number of synchronizer flops on each strobe input; legal values are 2 and 3.

Ports:
- `clk` in 1: 25.175 MHz dot clock from the global buffer.
- `rst` in 1: reset, synchronous and active-high.
- `hostBusAddr` in 11: host address; stable while a strobe is low.
- `hostBusDataIn` in 8: host bus data, input half of the top-level tristate.
- `nHostRMEM`, `nHostWMEM` in 1 each: asynchronous active-low read and write strobes.
- `nHostVRAMEn`, `nHostBankRegEn` in 1 each: asynchronous active-low selects.
- `hostRdData` in 8: read data from the `vram` host port, valid 1 clk after the request.
- `hostAddr` out 13: VRAM host address, equal to {bank[1:0], latched hostBusAddr}.
- `hostWrData` out 8: latched write data.
- `hostSelect` out 1: one-clk VRAM access request, active-high.
- `hostRd` out 1: access type; 1 = read, 0 = write.
- `hostBusDataOut` out 8: read-data register, driven onto the bus by the top level.
- `hostBusDataOe` out 1: tristate enable for `hostBusDataOut`.
- `hostBusDir` out 1: transceiver direction; 0 = BUS_HOST_READ, 1 = BUS_HOST_WRITE.
- `bank` out 2: current bank register value.

## Operation
- **Synchronizers.** Each strobe passes through `SYNC_STAGES` flops plus one history flop. An access starts on a synced 1→0 edge.
- **Reset.** `rst` loads every sync and history flop with 0 (asserted). A strobe held low through reset therefore starts nothing; it must rise and fall again.
- **Address decode**, sampled at the start edge from the raw selects:
  - `nHostVRAMEn` low only → VRAM access.
  - `nHostBankRegEn` low only → bank access.
  - Both low or both high → no access. The FSM still goes to HOLD.
  - Both strobes synced low in the same cycle → no access, FSM to HOLD.
- **FSM states:**
  - IDLE: on a write start go to WR; on a read start go to RD; otherwise to HOLD as above. On any start, latch `hostBusAddr` and `hostBusDataIn`.
  - WR:
    - VRAM: `hostSelect`=1 and `hostRd`=0 for exactly 1 clk.
    - Bank: `bank` ← data[1:0]; `hostSelect` stays 0.
    - Next state: HOLD.
  - RD:
    - VRAM: `hostSelect`=1 and `hostRd`=1 for 1 clk.
    - Bank: no VRAM request.
    - Next state: RDCAP.
  - RDCAP: `hostBusDataOut` ← `hostRdData` for VRAM, or {6'b0, bank} for bank. Next state: HOLD.
  - HOLD: wait until both synced strobes are high, then go to IDLE.
- **Bank register.** A new bank value affects `hostAddr` from the next access onward. Display readout is unaffected.
- **Bus drive.** `hostBusDataOe` and `hostBusDir`=0 are combinational from the raw pins: `nHostRMEM`=0 AND exactly one select low. Otherwise `hostBusDataOe`=0 and `hostBusDir`=1.
- **Reset values:**
  - FSM IDLE, `bank`=0, `hostAddr`=0, `hostWrData`=0, `hostBusDataOut`=0.
  - `hostSelect`=0, `hostRd`=1.
  - Reset mid-access abandons the access. No partial write is issued after reset.

## Timing
- E = the first rising edge that samples a strobe low into sync stage 1. Figures below are for `SYNC_STAGES`=2; each extra stage adds 1 clk.
- Start is detected at E+1. Address and data are latched and the FSM enters WR/RD at E+2.
- `hostSelect` is high from E+2 to E+3.
- Bank write takes effect at E+2.
- `hostRdData` is valid at E+3. `hostBusDataOut` is updated at E+4 and holds until the next read completes.
- Host timing requirements:
  - Strobe low for at least 6 clk (≈240 ns).
  - Read data sampled no earlier than 5 clk after the strobe falls.
  - Strobe high for at least 3 clk between accesses.
- Throughput: at most one access per strobe pulse. `hostSelect` never stays high for 2 consecutive clks.

## Test plan
- Reset, then VRAM write, bank=0, addr 0x123, data 0xA5, strobe low 8 clk → exactly one `hostSelect` pulse with `hostRd`=0, `hostAddr`=0x0123, `hostWrData`=0xA5, issued at E+2.
- Bank write of 0x02, then VRAM read at addr 0x7FF with the model returning 0x3C → `hostAddr`=0x17FF, `hostRd`=1; `hostBusDataOut`=0x3C from E+4; `hostBusDataOe`=1 and `hostBusDir`=0 only while `nHostRMEM` is low.
- Bank read after bank write 0xFF → `bank`=3, `hostBusDataOut`=0x03, no `hostSelect`.
- Both selects low on a write, and separately both strobes low together → no `hostSelect`, `bank` unchanged, FSM returns to IDLE after the strobes rise.
- Strobe held low across `rst` → no access while held; the next full pulse performs a normal access.
- Strobe held low 50 clk → a single `hostSelect` pulse only.
